nios_system_gpio_0_debounce: RTL and testbench
==============================================

# nios_system_gpio_0_debounce

Input-conditioning stage placed directly upstream of the GPIO input port. It takes a raw, asynchronous, bouncing 1-bit pin (push-button or switch), synchronizes it into `clk`, and qualifies each level change over a programmable stable window. It then drives a clean level into the PIO `in_port`, together with single-cycle edge pulses and a saturating edge counter for debug and interrupt use.

## Interface
- `DEBOUNCE_CYCLES`, 50000: required stable duration in `clk` cycles (1 ms at 50 MHz). Legal range is ≥ 1.
- `CNT_W`, 16: width of the qualify counter. It must hold `DEBOUNCE_CYCLES-1`.
- `EDGE_CNT_W`, 8: width of `edge_count`.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `raw_in`  in  1  asynchronous pin input.
- `clear_count`  in  1  synchronous clear of `edge_count`.
- `level_out`  out  1  debounced level; connects to the GPIO `in_port`.
- `rise_pulse`  out  1  one-cycle pulse when `level_out` goes 0→1.
- `fall_pulse`  out  1  one-cycle pulse when `level_out` goes 1→0.
- `edge_count`  out  `EDGE_CNT_W`  count of qualified level changes; saturating.
- `unstable`  out  1  high while a candidate change is being qualified.

## Operation
- **Synchronizer:** two flops, `sync1 <= raw_in` and `sync2 <= sync1`. No logic between the two flops. Only `sync2` is used downstream.
- **FSM, two states, all outputs registered:**
  - **STABLE:** if `sync2 != level_out`, go to QUALIFY and set `cnt <= 0`. Otherwise hold.
  - **QUALIFY, bounce back:** if `sync2 == level_out`, go to STABLE and set `cnt <= 0`. No output change and no pulse.
  - **QUALIFY, qualified:** if `sync2 != level_out` and `cnt == DEBOUNCE_CYCLES-1`, then `level_out <= sync2`, assert the matching pulse, go to STABLE, and set `cnt <= 0`.
  - **QUALIFY, otherwise:** `cnt <= cnt+1`.
- **`unstable`:** equals (state == QUALIFY). It is decoded from the state register, with no extra flop.
- **Pulses:** `rise_pulse` and `fall_pulse` are registered and default to 0 each cycle. They are never high together.
- **`edge_count`:**
  - Increments by 1 on each qualified change in either direction.
  - Saturates at all-ones; it does not wrap.
  - `clear_count` forces 0. If `clear_count` and a qualified change land in the same cycle, clear wins: the count is 0 and that event is not counted.
- **Width rule:** `cnt` is unsigned `CNT_W` bits. The compare uses `DEBOUNCE_CYCLES-1` truncated to `CNT_W`. Choosing a correct `CNT_W` is the integrator's responsibility.

## Timing
- **Reset values** (`reset` sampled high on a rising edge):
  - Registers: `sync1`, `sync2`, `cnt`, `level_out`, `rise_pulse`, `fall_pulse` and `edge_count` = 0.
  - State = STABLE, so `unstable` = 0.
- **Reset mid-operation:** reset during QUALIFY aborts the qualification with no pulse and no count. If `raw_in` is high when reset is released, it requalifies as a normal rise: full latency, `rise_pulse` asserted, `edge_count` = 1.
- **Latency:** count as edge 1 the first rising edge at which `sync1` samples the new stable `raw_in`. `level_out` and the pulse update on edge `DEBOUNCE_CYCLES+3`.
- **Glitch filtering:**
  - Any return of `sync2` to the old level during QUALIFY restarts qualification from scratch on the next mismatch.
  - A pulse on `raw_in` shorter than `DEBOUNCE_CYCLES+1` cycles never reaches `level_out`.
- **`DEBOUNCE_CYCLES = 1`:** the change commits on the first QUALIFY cycle, for a latency of 4 edges.
- **Throughput:** at most one qualified change per `DEBOUNCE_CYCLES+1` cycles. The FSM spends at least one cycle in STABLE between changes.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES=4`, `CNT_W=3` and `EDGE_CNT_W=2`.

- **Reset:** hold `reset` high for 3 cycles with `raw_in=1` → during reset all outputs are 0. After release, `level_out` rises on edge 7, `rise_pulse`=1 for exactly that cycle, `edge_count`=1.
- **Clean step:** `raw_in` 0→1 and held → `level_out`=1 exactly 7 edges after first sample, `rise_pulse` for one cycle, `unstable`=1 for the 4 cycles before.
- **Bounce:** `raw_in` 0→1 for 3 cycles, back to 0 for 1 cycle, then 1 steadily → no change after the first burst; `level_out` rises 7 edges after the final transition; `edge_count`=1.
- **Short glitch:** 1-cycle high pulse on `raw_in` → `level_out` stays 0, no pulses, `edge_count` unchanged, `unstable` high for 1 cycle.
- **Saturation:** 5 qualified changes alternating 0/1 → `edge_count` goes 1, 2, 3, 3, 3. Pulses alternate rise/fall.
- **Clear collision:** assert `clear_count` on the same cycle as a qualified fall → `edge_count`=0 and `fall_pulse`=1. The next change makes `edge_count`=1.

Source files
------------

// File: rtl/nios_system_gpio_0_debounce.sv
// Pin conditioner for the GPIO input port: two-flop synchronizer, stable-window qualifier,
// registered edge pulses and a saturating count of qualified level changes.
module nios_system_gpio_0_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned EDGE_CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  raw_in,
    input  logic                  clear_count,
    output logic                  level_out,
    output logic                  rise_pulse,
    output logic                  fall_pulse,
    output logic [EDGE_CNT_W-1:0] edge_count,
    output logic                  unstable
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        StStable,
        StQualify
    } state_e;

    state_e                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    level_q, level_d;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;
    logic [EDGE_CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                    qualified;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= StStable;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            sync1_q    <= raw_in;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        qualified = 1'b0;

        unique case (state_q)
            StStable: begin
                if (sync2_q != level_q) begin
                    state_d = StQualify;
                    cnt_d   = '0;
                end
            end
            StQualify: begin
                if (sync2_q == level_q) begin
                    // Bounced back: drop the candidate, restart from scratch on the next mismatch.
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    level_d   = sync2_q;
                    rise_d    = sync2_q;
                    fall_d    = ~sync2_q;
                    qualified = 1'b1;
                    state_d   = StStable;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StStable;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear takes priority over a change committing in the same cycle.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (clear_count) begin
            edge_cnt_d = '0;
        end else if (qualified && (edge_cnt_q != {EDGE_CNT_W{1'b1}})) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign edge_count = edge_cnt_q;
    assign unstable   = (state_q == StQualify);

endmodule

// File: tb/tb_nios_system_gpio_0_debounce.sv
// Bench for the GPIO debouncer: directed scenarios plus random pin activity, checked against a
// run-length model of the qualification rule.
module tb_nios_system_gpio_0_debounce;

    localparam int unsigned D  = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned EW = 2;

    logic          clk         = 1'b0;
    logic          reset       = 1'b1;
    logic          raw_in      = 1'b0;
    logic          clear_count = 1'b0;
    logic          level_out;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [EW-1:0] edge_count;
    logic          unstable;

    nios_system_gpio_0_debounce #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW),
        .EDGE_CNT_W     (EW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .clear_count(clear_count),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .edge_count (edge_count),
        .unstable   (unstable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: pin delayed by two samples; a change commits once the delayed pin has disagreed
    // with the level for D+1 consecutive samples.
    bit m_s1, m_s2, m_lvl, m_rp, m_fp;
    int m_run, m_ec;

    task automatic tick();
        bit seen;
        bit committed;
        @(posedge clk);
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rp = 0; m_fp = 0; m_run = 0; m_ec = 0;
        end else begin
            seen      = m_s2;
            m_s2      = m_s1;
            m_s1      = raw_in;
            m_rp      = 0;
            m_fp      = 0;
            committed = 0;
            if (seen != m_lvl) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_lvl     = seen;
                    m_rp      = seen;
                    m_fp      = !seen;
                    m_run     = 0;
                    committed = 1;
                end
            end else begin
                m_run = 0;
            end
            if (clear_count) m_ec = 0;
            else if (committed && m_ec < (1 << EW) - 1) m_ec++;
        end
        #1;
    endtask

    function automatic logic [5:0] exp_vec();
        logic [EW-1:0] ec;
        ec = EW'(m_ec);
        return {m_lvl, m_rp, m_fp, (m_run != 0), ec};
    endfunction

    function automatic logic [5:0] dut_vec();
        return {level_out, rise_pulse, fall_pulse, unstable, edge_count};
    endfunction

    task automatic settle(input bit lvl);
        raw_in = lvl;
        repeat (12) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL settle: got %b expected %b", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        raw_in = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (dut_vec() !== 6'b000000) begin
                errors++;
                $display("FAIL reset_hold: got %b expected %b", dut_vec(), 6'b000000);
            end
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_release e%0d: got %b expected %b", e, dut_vec(), exp_vec());
            end
            if (e == 6) begin
                checks++;
                if (dut_vec() !== 6'b000100) begin
                    errors++;
                    $display("FAIL reset_e6: got %b expected %b", dut_vec(), 6'b000100);
                end
            end
            if (e == 7) begin
                checks++;
                if (dut_vec() !== 6'b110001) begin
                    errors++;
                    $display("FAIL reset_e7: got %b expected %b", dut_vec(), 6'b110001);
                end
            end
            if (e == 8) begin
                checks++;
                if (dut_vec() !== 6'b100001) begin
                    errors++;
                    $display("FAIL reset_e8: got %b expected %b", dut_vec(), 6'b100001);
                end
            end
        end
    endtask

    task automatic test_clean_step();
        int found = -1;
        int unst  = 0;
        int rises = 0;
        settle(1'b0);
        raw_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clean_step e%0d: got %b expected %b", e, dut_vec(), exp_vec());
            end
            if (level_out === 1'b1 && found < 0) found = e;
            if (found < 0 && unstable === 1'b1) unst++;
            if (rise_pulse === 1'b1) rises++;
        end
        checks++;
        if (found != 7 || unst != 4 || rises != 1) begin
            errors++;
            $display("FAIL clean_step_latency: got edge %0d unstable %0d rises %0d expected 7 4 1",
                     found, unst, rises);
        end
    endtask

    task automatic test_bounce();
        int found = -1;
        settle(1'b0);
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        raw_in = 1'b1;
        repeat (3) tick();
        raw_in = 1'b0;
        tick();
        checks++;
        if (dut_vec() !== exp_vec() || level_out !== 1'b0) begin
            errors++;
            $display("FAIL bounce_burst: got %b expected %b", dut_vec(), exp_vec());
        end
        raw_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bounce e%0d: got %b expected %b", e, dut_vec(), exp_vec());
            end
            if (level_out === 1'b1 && found < 0) found = e;
        end
        checks++;
        if (found != 7 || edge_count !== 2'd1) begin
            errors++;
            $display("FAIL bounce_result: got edge %0d count %0d expected 7 1", found, edge_count);
        end
    endtask

    task automatic test_glitch();
        logic [EW-1:0] ec0;
        int unst   = 0;
        int pulses = 0;
        int highs  = 0;
        settle(1'b0);
        ec0    = edge_count;
        raw_in = 1'b1;
        tick();
        raw_in = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL glitch e%0d: got %b expected %b", e, dut_vec(), exp_vec());
            end
            if (unstable === 1'b1) unst++;
            if (rise_pulse === 1'b1 || fall_pulse === 1'b1) pulses++;
            if (level_out === 1'b1) highs++;
        end
        checks++;
        if (unst != 1 || pulses != 0 || highs != 0 || edge_count !== ec0) begin
            errors++;
            $display("FAIL glitch_result: got unst %0d pulses %0d highs %0d count %0d expected 1 0 0 %0d",
                     unst, pulses, highs, edge_count, ec0);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt[5] = '{1, 2, 3, 3, 3};
        settle(1'b0);
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        for (int i = 0; i < 5; i++) begin
            int rises = 0;
            int falls = 0;
            raw_in = (i % 2 == 0);
            repeat (8) begin
                tick();
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL saturation %0d: got %b expected %b", i, dut_vec(), exp_vec());
                end
                if (rise_pulse === 1'b1) rises++;
                if (fall_pulse === 1'b1) falls++;
            end
            checks++;
            if (edge_count !== EW'(exp_cnt[i]) || rises != (i % 2 == 0 ? 1 : 0)
                || falls != (i % 2 == 0 ? 0 : 1)) begin
                errors++;
                $display("FAIL saturation_step %0d: got count %0d rise %0d fall %0d expected %0d",
                         i, edge_count, rises, falls, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_clear_collision();
        settle(1'b1);
        raw_in = 1'b0;
        repeat (6) tick();
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        checks++;
        if (dut_vec() !== 6'b001000) begin
            errors++;
            $display("FAIL clear_collision: got %b expected %b", dut_vec(), 6'b001000);
        end
        raw_in = 1'b1;
        repeat (7) tick();
        checks++;
        if (dut_vec() !== 6'b110001) begin
            errors++;
            $display("FAIL clear_next: got %b expected %b", dut_vec(), 6'b110001);
        end
    endtask

    task automatic test_reset_mid();
        settle(1'b1);
        raw_in = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        raw_in = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== 6'b000000) begin
            errors++;
            $display("FAIL reset_mid: got %b expected %b", dut_vec(), 6'b000000);
        end
        reset = 1'b0;
        repeat (7) tick();
        checks++;
        if (dut_vec() !== 6'b110001) begin
            errors++;
            $display("FAIL reset_mid_requal: got %b expected %b", dut_vec(), 6'b110001);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                raw_in = ~raw_in;
                hold   = $urandom_range(1, 9);
            end
            hold--;
            clear_count = ($urandom_range(0, 15) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random c%0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
        end
        reset       = 1'b0;
        clear_count = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_saturation();
        test_clear_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
